// File: rtl/b_feeder.sv
`timescale 1ns / 1ps
// b_feeder: upstream stage of the B-operand skew FIFO bank.
//
// Accepts one DIM x DIM tile of signed elements row by row over a valid/ready
// write port, then streams it into the skew bank one vector per cycle with a
// matching enable. After the tile it pushes zero vectors until the deepest
// skew FIFO (depth 2*DIM-1) has drained, then pulses done.
//
// Optional feature, macro B_FEEDER_TRANSPOSE_EN: when defined, STREAM emits
// tile columns instead of rows (the row-major tile is fed as its transpose).
// When undefined, rows are emitted and no transpose mux exists.
//
// Ports:
//   clk       clock
//   rst_n     asynchronous active-low reset
//   start     pulse, begins a tile load (honoured only when idle)
//   wr_valid  wr_row holds a valid row
//   wr_ready  feeder accepts a row this cycle (high throughout LOAD)
//   wr_row    one tile row; element i is column i
//   busy      high whenever not idle
//   done      one-cycle pulse on return to idle after the flush
//   en_out    registered shift enable to the skew bank
//   Bout      registered vector to the skew bank input
module b_feeder #(
  parameter int unsigned BITS_AB = 8,
  parameter int unsigned DIM     = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic signed [BITS_AB-1:0] wr_row [DIM],
  output logic                      busy,
  output logic                      done,
  output logic                      en_out,
  output logic signed [BITS_AB-1:0] Bout [DIM]
);

  localparam int unsigned RowW     = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int unsigned FlushLen = 2 * DIM - 1;
  localparam int unsigned FlushW   = $clog2(FlushLen);

  localparam logic [RowW-1:0]   RowLast   = RowW'(DIM - 1);
  localparam logic [FlushW-1:0] FlushLast = FlushW'(FlushLen - 1);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StStream,
    StFlush
  } state_e;

  state_e state_q, state_d;

  logic [RowW-1:0]   row_cnt_q, row_cnt_d;
  logic [FlushW-1:0] flush_cnt_q, flush_cnt_d;

  logic signed [BITS_AB-1:0] tile_q [DIM][DIM];
  logic signed [BITS_AB-1:0] tile_d [DIM][DIM];

  logic                      done_q, done_d;
  logic                      en_out_q, en_out_d;
  logic signed [BITS_AB-1:0] bout_q [DIM];
  logic signed [BITS_AB-1:0] bout_d [DIM];

  // Vector selected for the next output register load. Outputs are computed
  // from the upcoming state so the registered enable lines up with STREAM and
  // FLUSH occupancy: the first vector appears the cycle right after the last
  // handshake and en_out is low again in the done cycle.
  logic            emit;
  logic [RowW-1:0] emit_idx;

  always_comb begin
    state_d     = state_q;
    row_cnt_d   = row_cnt_q;
    flush_cnt_d = flush_cnt_q;
    tile_d      = tile_q;
    done_d      = 1'b0;
    en_out_d    = 1'b0;
    emit        = 1'b0;
    emit_idx    = '0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StLoad;
          row_cnt_d = '0;
        end
      end

      StLoad: begin
        // wr_ready is high for the whole state, so wr_valid is the handshake.
        if (wr_valid) begin
          tile_d[row_cnt_q] = wr_row;
          if (row_cnt_q == RowLast) begin
            state_d   = StStream;
            row_cnt_d = '0;
            emit      = 1'b1;
            emit_idx  = '0;
          end else begin
            row_cnt_d = row_cnt_q + RowW'(1);
          end
        end
      end

      StStream: begin
        if (row_cnt_q == RowLast) begin
          state_d     = StFlush;
          row_cnt_d   = '0;
          flush_cnt_d = '0;
          en_out_d    = 1'b1;
        end else begin
          row_cnt_d = row_cnt_q + RowW'(1);
          emit      = 1'b1;
          emit_idx  = row_cnt_q + RowW'(1);
        end
      end

      StFlush: begin
        if (flush_cnt_q == FlushLast) begin
          state_d     = StIdle;
          flush_cnt_d = '0;
          done_d      = 1'b1;
        end else begin
          flush_cnt_d = flush_cnt_q + FlushW'(1);
          en_out_d    = 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    if (emit) begin
      en_out_d = 1'b1;
    end
  end

  // Output vector mux. Reads tile_d so the final row written in the same
  // cycle as the last handshake is already visible (needed for column 0 in
  // transpose mode, harmless otherwise).
  always_comb begin
    for (int i = 0; i < DIM; i++) begin
      bout_d[i] = '0;
      if (emit) begin
`ifdef B_FEEDER_TRANSPOSE_EN
        bout_d[i] = tile_d[i][emit_idx];
`else
        bout_d[i] = tile_d[emit_idx][i];
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      row_cnt_q   <= '0;
      flush_cnt_q <= '0;
      done_q      <= 1'b0;
      en_out_q    <= 1'b0;
      for (int r = 0; r < DIM; r++) begin
        bout_q[r] <= '0;
        for (int c = 0; c < DIM; c++) begin
          tile_q[r][c] <= '0;
        end
      end
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      done_q      <= done_d;
      en_out_q    <= en_out_d;
      for (int r = 0; r < DIM; r++) begin
        bout_q[r] <= bout_d[r];
        for (int c = 0; c < DIM; c++) begin
          tile_q[r][c] <= tile_d[r][c];
        end
      end
    end
  end

  assign wr_ready = (state_q == StLoad);
  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign en_out   = en_out_q;
  assign Bout     = bout_q;

endmodule

// File: doc/b_feeder.md
Name: b_feeder

Overview:
- Upstream stage of the B-operand skew FIFO bank (`memB`) in the systolic matrix-multiply datapath.
- Accepts one DIM×DIM B tile, row by row, over a valid/ready write port and stores it locally.
- Streams the tile into the skew bank one row vector per cycle with a matching enable.
- Then pushes zero vectors until the deepest skew FIFO (depth 2*DIM-1) has drained. Signals done.

Parameters:
- BITS_AB, 8, signed element width; must match the skew bank.
- DIM, 8, tile dimension and vector length; must be ≥2.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset. One clock; reset is asynchronous and active-low.
- start  input  1  pulse; begins a tile load. Honoured only in IDLE.
- wr_valid  input  1  wr_row holds a valid row.
- wr_ready  output  1  feeder accepts a row this cycle.
- wr_row  input  signed [BITS_AB-1:0] ×DIM (unpacked)  one tile row; element i is column i.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse at end of flush.
- en_out  output  1  shift enable to the skew bank.
- Bout  output  signed [BITS_AB-1:0] ×DIM (unpacked)  vector to the skew bank input.

Behaviour:
- States: IDLE, LOAD, STREAM, FLUSH. Counters row_cnt (0..DIM-1) and flush_cnt (0..2*DIM-2) are $clog2-sized.
- Reset (async): state=IDLE, counters=0, tile storage=0, wr_ready=0, busy=0, done=0, en_out=0, Bout all 0.
- IDLE:
  - wr_ready=0.
  - start=1 → LOAD next cycle with row_cnt=0.
  - wr_valid is ignored.
- LOAD:
  - wr_ready=1 combinationally from state.
  - A handshake (wr_valid & wr_ready) writes tile[row_cnt] ← wr_row and increments row_cnt.
  - The handshake at row_cnt=DIM-1 → STREAM and clears row_cnt.
  - wr_valid=0 cycles stall with no write.
  - start is ignored.
- STREAM:
  - DIM cycles; each cycle registers Bout[i] ← tile[row_cnt][i] and en_out ← 1, then increments row_cnt.
  - After row DIM-1 → FLUSH.
  - wr_ready=0.
- FLUSH:
  - 2*DIM-1 cycles; each cycle registers Bout ← 0 and en_out ← 1.
  - After the last cycle → IDLE; done=1 for exactly that IDLE-entry cycle; en_out ← 0 and Bout ← 0.
- Output timing:
  - Bout and en_out are registered.
  - First en_out=1 (carrying row 0) occurs the cycle after the final LOAD handshake.
  - en_out is then high for exactly 3*DIM-1 consecutive cycles with no gaps.
- Back-to-back tiles:
  - start in the done cycle is accepted; LOAD begins the following cycle.
  - start during busy is dropped, not queued.
- busy = (state != IDLE); deasserts in the same cycle done pulses.
- Tile storage is not cleared between tiles; every entry is overwritten by LOAD before use.
- No arithmetic; elements pass through bit-exact.
- Reset mid-operation: immediate return to reset values. No partial stream or flush completes, and no done pulse is generated.

Optional Feature:
- Macro: B_FEEDER_TRANSPOSE_EN.
- Defined: STREAM drives Bout[i] ← tile[i][row_cnt], i.e. emits columns. The tile is loaded row-major but fed as Bᵀ. All timing is unchanged.
- Undefined: row order as above; no transpose mux is synthesised.

Test Plan (DIM=4, BITS_AB=8):
- Reset:
  - Stimulus: assert rst_n=0 with random inputs.
  - Response: all outputs 0, busy=0.
  - Stimulus: release, then hold wr_valid=1 with no start.
  - Response: wr_ready stays 0.
- Basic tile:
  - Stimulus: start; rows {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16} on consecutive cycles.
  - Response: Bout = those rows on 4 consecutive en_out cycles beginning the cycle after the 4th handshake; then 7 zero cycles; done pulses once; total 11 en_out cycles.
- Stalled load:
  - Stimulus: same rows with wr_valid low 2 cycles between each.
  - Response: identical Bout sequence; no extra en_out; rows stored in handshake order.
- Back-to-back / dropped start:
  - Stimulus: start during STREAM → ignored.
  - Stimulus: start in the done cycle with a second tile {-1,-2,-3,-4}… → loaded and streamed; values are signed-exact, e.g. 8'hFF seen as -1.
- Reset mid-stream:
  - Stimulus: rst_n=0 after 2 STREAM cycles.
  - Response: en_out and Bout are 0 immediately; no done.
  - Stimulus: a subsequent full tile.
  - Response: streams correctly.
- Transpose (with B_FEEDER_TRANSPOSE_EN):
  - Stimulus: basic tile.
  - Response: Bout sequence {1,5,9,13},{2,6,10,14},{3,7,11,15},{4,8,12,16}, then 7 zero cycles.
